// File: rtl/num_cmp_bist.sv
// Self-test driver for a WIDTH-bit magnitude comparator: sweeps all (A,B) pairs, checks Y2/Y1/Y0, counts mismatches.
// Optional first-failure capture ports are compiled in with NUM_CMP_BIST_FAIL_CAPTURE_EN.
module num_cmp_bist #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic               y1_in,
  input  logic               y2_in,
  input  logic               y0_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_cnt
`ifdef NUM_CMP_BIST_FAIL_CAPTURE_EN
  ,
  output logic               fail_vld,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b,
  output logic [2:0]         fail_y
`endif
);

  // state | meaning
  // IDLE  | waiting for start after reset
  // RUN   | sweeping vectors, busy=1
  // DONE  | sweep finished, results held until next start
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int IW = 2 * WIDTH;
  localparam int EW = IW + 1;
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0] WAIT_INIT = CW'(SETTLE);

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [CW-1:0]   wait_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [EW-1:0]   err_q;
  logic [EW-1:0]   err_d;

  logic [WIDTH-1:0] a_cur;
  logic [WIDTH-1:0] b_cur;
  logic [2:0]       exp_flags;
  logic [2:0]       got_flags;
  logic             mism;
  logic             last_vec;
  logic             sample;

`ifdef NUM_CMP_BIST_FAIL_CAPTURE_EN
  logic             fail_vld_q;
  logic [WIDTH-1:0] fail_a_q;
  logic [WIDTH-1:0] fail_b_q;
  logic [2:0]       fail_y_q;
`endif

  assign a_cur     = idx_q[WIDTH-1:0];
  assign b_cur     = idx_q[IW-1:WIDTH];
  assign exp_flags = {a_cur < b_cur, a_cur > b_cur, a_cur == b_cur};
  assign got_flags = {y2_in, y1_in, y0_in};
  assign mism      = (got_flags != exp_flags);
  assign err_d     = err_q + EW'(mism);
  assign last_vec  = &idx_q;
  assign sample    = (wait_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
`ifdef NUM_CMP_BIST_FAIL_CAPTURE_EN
      fail_vld_q <= 1'b0;
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      fail_y_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            idx_q   <= '0;
            wait_q  <= WAIT_INIT;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
`ifdef NUM_CMP_BIST_FAIL_CAPTURE_EN
            fail_vld_q <= 1'b0;
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_y_q   <= '0;
`endif
          end
        end
        RUN: begin
          if (!sample) begin
            wait_q <= wait_q - CW'(1);
          end else begin
            err_q <= err_d;
`ifdef NUM_CMP_BIST_FAIL_CAPTURE_EN
            if (mism && !fail_vld_q) begin
              fail_vld_q <= 1'b1;
              fail_a_q   <= a_cur;
              fail_b_q   <= b_cur;
              fail_y_q   <= got_flags;
            end
`endif
            // The last vector's sample ends the sweep; operands hold rather than wrap.
            if (last_vec) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              idx_q  <= idx_q + IW'(1);
              wait_q <= WAIT_INIT;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_out   = a_cur;
  assign b_out   = b_cur;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;

`ifdef NUM_CMP_BIST_FAIL_CAPTURE_EN
  assign fail_vld = fail_vld_q;
  assign fail_a   = fail_a_q;
  assign fail_b   = fail_b_q;
  assign fail_y   = fail_y_q;
`endif

endmodule

// File: tb/tb_num_cmp_bist.sv
// Bench for num_cmp_bist: drives two instances (SETTLE=1 and SETTLE=0) from a behavioural comparator with selectable faults.
module tb_num_cmp_bist;
  localparam int N = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       st1, st0;
  logic [3:0] a1, b1, a0, b0;
  logic       y1_1, y2_1, y0_1, y1_0, y2_0, y0_0;
  logic       busy1, done1, pass1, busy0, done0, pass0;
  logic [8:0] err1, err0;
`ifdef NUM_CMP_BIST_FAIL_CAPTURE_EN
  logic       fv1, fv0;
  logic [3:0] fa1, fb1, fa0, fb0;
  logic [2:0] fy1, fy0;
`endif

  num_cmp_bist #(.WIDTH(4), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(st1), .a_out(a1), .b_out(b1),
    .y1_in(y1_1), .y2_in(y2_1), .y0_in(y0_1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1)
`ifdef NUM_CMP_BIST_FAIL_CAPTURE_EN
    , .fail_vld(fv1), .fail_a(fa1), .fail_b(fb1), .fail_y(fy1)
`endif
  );

  num_cmp_bist #(.WIDTH(4), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .a_out(a0), .b_out(b0),
    .y1_in(y1_0), .y2_in(y2_0), .y0_in(y0_0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0)
`ifdef NUM_CMP_BIST_FAIL_CAPTURE_EN
    , .fail_vld(fv0), .fail_a(fa0), .fail_b(fb0), .fail_y(fy0)
`endif
  );

  // comparator behaviour: 0 ideal, 1 y0 stuck 0, 2 y1/y2 swapped, 3 y1 stuck 1, 4 all flags 0, 5 random XOR mask
  int         mode;
  logic [2:0] mask [N];
  int         checks = 0;
  int         errors = 0;

  function automatic logic [2:0] ideal(input logic [3:0] a, input logic [3:0] b);
    return {a < b, a > b, a == b};
  endfunction

  function automatic logic [2:0] model(input logic [3:0] a, input logic [3:0] b);
    logic [2:0] id;
    id = ideal(a, b);
    case (mode)
      0:       return id;
      1:       return {id[2:1], 1'b0};
      2:       return {id[1], id[2], id[0]};
      3:       return {id[2], 1'b1, id[0]};
      4:       return 3'b000;
      default: return id ^ mask[{b, a}];
    endcase
  endfunction

  always_comb begin
    {y2_1, y1_1, y0_1} = 3'b000;
    {y2_1, y1_1, y0_1} = model(a1, b1);
  end
  always_comb begin
    {y2_0, y1_0, y0_0} = 3'b000;
    {y2_0, y1_0, y0_0} = model(a0, b0);
  end

  function automatic int ref_err();
    int n = 0;
    for (int i = 0; i < N; i++) begin
      logic [7:0] v;
      v = 8'(i);
      if (model(v[3:0], v[7:4]) != ideal(v[3:0], v[7:4])) n++;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run_sweep(input bit sel0, input int exp_err, input bit exp_pass,
                           input bit poke, input string tag);
    int settle;
    int n;
    int cyc;
    int step_bad;
    settle = sel0 ? 0 : 1;
    n = N * (settle + 1);
    @(negedge clk);
    if (sel0) st0 = 1'b1; else st1 = 1'b1;
    @(negedge clk);
    st0 = 1'b0; st1 = 1'b0;
    check({tag, " busy_after_start"}, sel0 ? busy0 : busy1, 1);
    check({tag, " done_cleared"}, sel0 ? done0 : done1, 0);
    check({tag, " err_cleared"}, sel0 ? err0 : err1, 0);
    cyc = 0;
    step_bad = 0;
    while ((sel0 ? busy0 : busy1) && cyc < n + 100) begin
      cyc++;
      if (int'(sel0 ? {b0, a0} : {b1, a1}) != (cyc - 1) / (settle + 1)) step_bad++;
      if (poke && (cyc == 40 || cyc == 300 || cyc == n - 1)) begin
        if (sel0) st0 = 1'b1; else st1 = 1'b1;
      end else begin
        st0 = 1'b0; st1 = 1'b0;
      end
      @(negedge clk);
    end
    st0 = 1'b0; st1 = 1'b0;
    check({tag, " busy_cycles"}, cyc, n);
    check({tag, " vector_steps_bad"}, step_bad, 0);
    check({tag, " done"}, sel0 ? done0 : done1, 1);
    check({tag, " pass"}, sel0 ? pass0 : pass1, exp_pass);
    check({tag, " err_cnt"}, sel0 ? err0 : err1, exp_err);
    check({tag, " last_vector_held"}, sel0 ? {b0, a0} : {b1, a1}, 8'hFF);
`ifdef NUM_CMP_BIST_FAIL_CAPTURE_EN
    begin
      bit found;
      logic [7:0] v;
      logic [2:0] fy;
      found = 1'b0;
      v = '0;
      fy = '0;
      for (int i = 0; i < N && !found; i++) begin
        v = 8'(i);
        if (model(v[3:0], v[7:4]) != ideal(v[3:0], v[7:4])) begin
          found = 1'b1;
          fy = model(v[3:0], v[7:4]);
        end
      end
      if (!found) v = '0;
      check({tag, " fail_vld"}, sel0 ? fv0 : fv1, found);
      check({tag, " fail_a"}, sel0 ? fa0 : fa1, v[3:0]);
      check({tag, " fail_b"}, sel0 ? fb0 : fb1, v[7:4]);
      check({tag, " fail_y"}, sel0 ? fy0 : fy1, fy);
    end
`endif
  endtask

  typedef struct {
    int    mode;
    int    exp_err;
    bit    exp_pass;
    string name;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int wait_cyc;
    tbl[0] = '{0, 0,   1'b1, "ideal"};
    tbl[1] = '{1, 16,  1'b0, "y0_stuck0"};
    tbl[2] = '{2, 240, 1'b0, "y1y2_swap"};
    tbl[3] = '{3, 136, 1'b0, "y1_stuck1"};
    tbl[4] = '{4, 256, 1'b0, "flags_zero"};
    for (int i = 0; i < N; i++) mask[i] = 3'b000;

    mode = 0;
    st1 = 1'b0; st0 = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", busy1, 0);
    check("rst done", done1, 0);
    check("rst pass", pass1, 0);
    check("rst err", err1, 0);
    check("rst ab", {b1, a1}, 0);
    check("rst busy0", busy0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      mode = tbl[i].mode;
      run_sweep(1'b0, tbl[i].exp_err, tbl[i].exp_pass, 1'b0, tbl[i].name);
    end

    mode = 0;
    run_sweep(1'b0, 0, 1'b1, 1'b1, "start_while_busy");

    mode = 1;
    @(negedge clk);
    st1 = 1'b1;
    @(negedge clk);
    st1 = 1'b0;
    wait_cyc = 0;
    while ({b1, a1} != 8'd100 && wait_cyc < 1000) begin
      wait_cyc++;
      @(negedge clk);
    end
    check("reach_idx100", {b1, a1}, 100);
    rst_n = 1'b0;
    #1;
    check("midrst busy", busy1, 0);
    check("midrst done", done1, 0);
    check("midrst pass", pass1, 0);
    check("midrst err", err1, 0);
    check("midrst ab", {b1, a1}, 0);
`ifdef NUM_CMP_BIST_FAIL_CAPTURE_EN
    check("midrst fail_vld", fv1, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(1'b0, 16, 1'b0, 1'b0, "after_midrst");

    mode = 0;
    run_sweep(1'b1, 0, 1'b1, 1'b0, "settle0_ideal");
    mode = 2;
    run_sweep(1'b1, 240, 1'b0, 1'b0, "settle0_swap");

    mode = 5;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++)
        mask[i] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      run_sweep(t == 3, ref_err(), ref_err() == 0, t == 1, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
